// File: rtl/fill_assembler_pkg.sv
// rtl/fill_assembler_pkg.sv - default sizes, fill request type and sizing helper for the fill assembler
package fill_assembler_pkg;

    localparam int DEF_CACHE_LINE_SIZE = 64;
    localparam int DEF_MEM_BEAT_SIZE   = 16;
    localparam int DEF_LINE_ADDR_WIDTH = 26;
    localparam int DEF_TAG_WIDTH       = 4;

    // $clog2 floored at one bit so a single-beat line still gets a counter.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEATS_PER_LINE = DEF_CACHE_LINE_SIZE / DEF_MEM_BEAT_SIZE;
    localparam int BEAT_SEL_BITS  = up_clog2(BEATS_PER_LINE);

    typedef struct packed {
        logic [DEF_LINE_ADDR_WIDTH-1:0]   addr;
        logic [DEF_TAG_WIDTH-1:0]         tag;
        logic [DEF_CACHE_LINE_SIZE*8-1:0] data;
    } fill_req_t;

endpackage

// File: rtl/fill_assembler_if.sv
// rtl/fill_assembler_if.sv - memory response beat bus and assembled fill bus
interface fill_assembler_if #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int TAG_WIDTH       = 4,
    parameter int BEAT_BITS       = 128,
    parameter int LINE_BITS       = 512
);
    logic                       mem_rsp_valid;
    logic [BEAT_BITS-1:0]       mem_rsp_data;
    logic [LINE_ADDR_WIDTH-1:0] mem_rsp_addr;
    logic [TAG_WIDTH-1:0]       mem_rsp_tag;
    logic                       mem_rsp_ready;
    logic                       fill_valid;
    logic [LINE_ADDR_WIDTH-1:0] fill_addr;
    logic [TAG_WIDTH-1:0]       fill_tag;
    logic [LINE_BITS-1:0]       fill_data;
    logic                       fill_ready;
    logic                       err_tag;

    modport master (
        output mem_rsp_valid, mem_rsp_data, mem_rsp_addr, mem_rsp_tag, fill_ready,
        input  mem_rsp_ready, fill_valid, fill_addr, fill_tag, fill_data, err_tag
    );

    modport slave (
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_addr, mem_rsp_tag, fill_ready,
        output mem_rsp_ready, fill_valid, fill_addr, fill_tag, fill_data, err_tag
    );
endinterface

// File: rtl/fill_assembler_out_reg.sv
// rtl/fill_assembler_out_reg.sv - one-entry valid/ready holding register for an assembled line
module fill_assembler_out_reg #(
    parameter type T = fill_assembler_pkg::fill_req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  T     in_data,
    output logic in_ready,
    output logic out_valid,
    output T     out_data,
    input  logic out_ready
);
    // A drain and a reload may share one edge, keeping out_valid high.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            out_data <= in_data;
        end
    end
endmodule

// File: rtl/fill_assembler.sv
// rtl/fill_assembler.sv - collects in-order memory beats into a full cache line and presents it as one fill
module fill_assembler
    import fill_assembler_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = DEF_CACHE_LINE_SIZE,
    parameter int MEM_BEAT_SIZE   = DEF_MEM_BEAT_SIZE,
    parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    fill_assembler_if.slave  bus
);
    localparam int BEATS     = CACHE_LINE_SIZE / MEM_BEAT_SIZE;
    localparam int BEAT_BITS = MEM_BEAT_SIZE * 8;
    localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
    localparam int CW        = up_clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef struct packed {
        logic [LINE_ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]       tag;
        logic [LINE_BITS-1:0]       data;
    } line_t;

    logic [CW-1:0]              beat_cnt;
    logic [LINE_ADDR_WIDTH-1:0] addr_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic                       err_q;
    logic                       is_last;
    logic                       accept;
    logic                       out_in_ready;
    logic                       out_valid;
    logic [LINE_BITS-1:0]       line_data;
    line_t                      line_in;
    line_t                      line_out;

    assign is_last           = (beat_cnt == LAST_BEAT);
    assign bus.mem_rsp_ready = ~is_last | out_in_ready;
    assign accept            = bus.mem_rsp_valid & bus.mem_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            beat_cnt <= is_last ? '0 : beat_cnt + CW'(1);
            if (beat_cnt == '0) begin
                addr_q <= bus.mem_rsp_addr;
                tag_q  <= bus.mem_rsp_tag;
            end else if (bus.mem_rsp_addr != addr_q || bus.mem_rsp_tag != tag_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // The last beat bypasses the buffer and goes straight into the output register.
    generate
        if (BEATS > 1) begin : g_asm
            logic [LINE_BITS-BEAT_BITS-1:0] asm_q;
            always_ff @(posedge clk) begin
                if (accept) begin
                    for (int k = 0; k < BEATS - 1; k++) begin
                        if (beat_cnt == CW'(k)) begin
                            asm_q[k*BEAT_BITS +: BEAT_BITS] <= bus.mem_rsp_data;
                        end
                    end
                end
            end
            assign line_data = {bus.mem_rsp_data, asm_q};
        end else begin : g_single
            assign line_data = bus.mem_rsp_data;
        end
    endgenerate

    // Single-beat lines never latch, so take addr/tag straight from the bus.
    assign line_in.addr = (beat_cnt == '0) ? bus.mem_rsp_addr : addr_q;
    assign line_in.tag  = (beat_cnt == '0) ? bus.mem_rsp_tag  : tag_q;
    assign line_in.data = line_data;

    fill_assembler_out_reg #(.T(line_t)) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept & is_last),
        .in_data   (line_in),
        .in_ready  (out_in_ready),
        .out_valid (out_valid),
        .out_data  (line_out),
        .out_ready (bus.fill_ready)
    );

    assign bus.fill_valid = out_valid;
    assign bus.fill_addr  = line_out.addr;
    assign bus.fill_tag   = line_out.tag;
    assign bus.fill_data  = line_out.data;
    assign bus.err_tag    = err_q;
endmodule

// File: tb/tb_fill_assembler.sv
// tb/tb_fill_assembler.sv - directed and randomized checks of fill_assembler against a line-level model
module tb_fill_assembler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt = 0;
    int acc_cyc = 0;

    fill_assembler_if #(.LINE_ADDR_WIDTH(26), .TAG_WIDTH(4), .BEAT_BITS(128), .LINE_BITS(512)) b4 ();
    fill_assembler_if #(.LINE_ADDR_WIDTH(26), .TAG_WIDTH(4), .BEAT_BITS(512), .LINE_BITS(512)) b1 ();

    fill_assembler u_dut4 (.clk(clk), .reset(reset), .bus(b4));
    fill_assembler #(.CACHE_LINE_SIZE(64), .MEM_BEAT_SIZE(64)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct {
        logic [25:0]  addr;
        logic [3:0]   tag;
        logic [511:0] data;
        int           c;
    } fill_rec_t;

    fill_rec_t    q4[$];
    logic [511:0] q1[$];

    always @(negedge clk) begin
        if (!reset && b4.fill_valid && b4.fill_ready)
            q4.push_back('{b4.fill_addr, b4.fill_tag, b4.fill_data, cyc});
        if (!reset && b1.fill_valid && b1.fill_ready)
            q1.push_back(b1.fill_data);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference line: beat k occupies bytes [16k, 16k+15].
    function automatic logic [511:0] mk_line(input logic [127:0] x0, input logic [127:0] x1,
                                             input logic [127:0] x2, input logic [127:0] x3);
        return (512'(x3) << 384) | (512'(x2) << 256) | (512'(x1) << 128) | 512'(x0);
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic [25:0] a, input logic [3:0] t);
        int waited = 0;
        b4.mem_rsp_valid = 1'b1;
        b4.mem_rsp_data  = d;
        b4.mem_rsp_addr  = a;
        b4.mem_rsp_tag   = t;
        @(negedge clk);
        while (!b4.mem_rsp_ready && waited < 200) begin
            waited++;
            stall_cnt++;
            @(negedge clk);
        end
        if (waited >= 200) chk("beat_accept_timeout", 512'(waited < 200), 512'(1));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic expect_fill(input string name, input logic [25:0] a, input logic [3:0] t,
                               input logic [511:0] d, output int c);
        fill_rec_t r;
        chk({name, "_present"}, 512'(q4.size() != 0), 512'(1));
        c = -1;
        if (q4.size() != 0) begin
            r = q4.pop_front();
            chk({name, "_addr"}, 512'(r.addr), 512'(a));
            chk({name, "_tag"}, 512'(r.tag), 512'(t));
            chk({name, "_data"}, r.data, d);
            c = r.c;
        end
    endtask

    logic [127:0] d2[3][4];
    logic [25:0]  a2[3];
    logic [3:0]   t2[3];
    int           c2[3];
    logic [127:0] ya[4];
    logic [127:0] yb[4];
    logic [25:0]  addr_a, addr_b;
    logic [3:0]   tag_a, tag_b;
    logic [511:0] line_a, line_b;
    logic [511:0] exp6[$];
    logic [511:0] w6;
    int           c, ca, cb, last_acc;

    initial begin
        b4.mem_rsp_valid = 1'b0; b4.mem_rsp_data = '0; b4.mem_rsp_addr = '0; b4.mem_rsp_tag = '0;
        b4.fill_ready = 1'b1;
        b1.mem_rsp_valid = 1'b0; b1.mem_rsp_data = '0; b1.mem_rsp_addr = '0; b1.mem_rsp_tag = '0;
        b1.fill_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        chk("rst_fill_valid", 512'(b4.fill_valid), 512'(0));
        chk("rst_err_tag", 512'(b4.err_tag), 512'(0));
        chk("rst_fill_valid_b1", 512'(b1.fill_valid), 512'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 512'(b4.mem_rsp_ready), 512'(1));
        @(posedge clk); #1;

        // 1: single line, latency one cycle after the last beat
        send_beat({16{8'h11}}, 26'h12345a, 4'h9);
        send_beat({16{8'h22}}, 26'h12345a, 4'h9);
        send_beat({16{8'h33}}, 26'h12345a, 4'h9);
        send_beat({16{8'h44}}, 26'h12345a, 4'h9);
        last_acc = acc_cyc;
        b4.mem_rsp_valid = 1'b0;
        tick(3);
        expect_fill("t1", 26'h12345a, 4'h9,
                    mk_line({16{8'h11}}, {16{8'h22}}, {16{8'h33}}, {16{8'h44}}), c);
        chk("t1_latency", 512'(c), 512'(last_acc));
        chk("t1_single", 512'(q4.size()), 512'(0));

        // 2: three back-to-back lines
        stall_cnt = 0;
        for (int l = 0; l < 3; l++) begin
            a2[l] = 26'($urandom);
            t2[l] = 4'($urandom);
            for (int k = 0; k < 4; k++) d2[l][k] = rnd128();
        end
        for (int l = 0; l < 3; l++)
            for (int k = 0; k < 4; k++) send_beat(d2[l][k], a2[l], t2[l]);
        b4.mem_rsp_valid = 1'b0;
        tick(3);
        chk("t2_no_stall", 512'(stall_cnt), 512'(0));
        for (int l = 0; l < 3; l++)
            expect_fill($sformatf("t2_line%0d", l), a2[l], t2[l],
                        mk_line(d2[l][0], d2[l][1], d2[l][2], d2[l][3]), c2[l]);
        chk("t2_gap01", 512'(c2[1] - c2[0]), 512'(4));
        chk("t2_gap12", 512'(c2[2] - c2[1]), 512'(4));

        // 3: fill_ready held low, second line's last beat must wait
        for (int k = 0; k < 4; k++) begin ya[k] = rnd128(); yb[k] = rnd128(); end
        addr_a = 26'($urandom); tag_a = 4'($urandom);
        addr_b = 26'($urandom); tag_b = 4'($urandom);
        line_a = mk_line(ya[0], ya[1], ya[2], ya[3]);
        line_b = mk_line(yb[0], yb[1], yb[2], yb[3]);
        b4.fill_ready = 1'b0;
        stall_cnt = 0;
        for (int k = 0; k < 4; k++) send_beat(ya[k], addr_a, tag_a);
        for (int k = 0; k < 3; k++) send_beat(yb[k], addr_b, tag_b);
        chk("t3_no_early_stall", 512'(stall_cnt), 512'(0));
        b4.mem_rsp_valid = 1'b1;
        b4.mem_rsp_data  = yb[3];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_stall_ready_%0d", i), 512'(b4.mem_rsp_ready), 512'(0));
            chk($sformatf("t3_hold_valid_%0d", i), 512'(b4.fill_valid), 512'(1));
            chk($sformatf("t3_hold_data_%0d", i), b4.fill_data, line_a);
            chk($sformatf("t3_hold_addr_%0d", i), 512'(b4.fill_addr), 512'(addr_a));
            @(posedge clk); #1;
        end
        b4.fill_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", 512'(b4.mem_rsp_ready), 512'(1));
        @(posedge clk); #1;
        b4.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t3_reload_valid", 512'(b4.fill_valid), 512'(1));
        chk("t3_reload_data", b4.fill_data, line_b);
        chk("t3_reload_tag", 512'(b4.fill_tag), 512'(tag_b));
        @(posedge clk); #1;
        tick(2);
        expect_fill("t3_line_a", addr_a, tag_a, line_a, ca);
        expect_fill("t3_line_b", addr_b, tag_b, line_b, cb);
        chk("t3_back_to_back", 512'(cb - ca), 512'(1));

        // 4: tag changes on beat 2
        for (int k = 0; k < 4; k++) ya[k] = rnd128();
        addr_a = 26'($urandom);
        send_beat(ya[0], addr_a, 4'h3);
        send_beat(ya[1], addr_a, 4'h3);
        b4.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t4_err_before", 512'(b4.err_tag), 512'(0));
        @(posedge clk); #1;
        send_beat(ya[2], addr_a, 4'h5);
        b4.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t4_err_set", 512'(b4.err_tag), 512'(1));
        @(posedge clk); #1;
        send_beat(ya[3], addr_a, 4'h5);
        b4.mem_rsp_valid = 1'b0;
        tick(5);
        expect_fill("t4", addr_a, 4'h3, mk_line(ya[0], ya[1], ya[2], ya[3]), c);
        @(negedge clk);
        chk("t4_err_sticky", 512'(b4.err_tag), 512'(1));
        @(posedge clk); #1;

        // 5: reset in the middle of a line discards the partial beats
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_err_cleared", 512'(b4.err_tag), 512'(0));
        @(posedge clk); #1;
        send_beat(rnd128(), 26'($urandom), 4'($urandom));
        send_beat(rnd128(), 26'($urandom), 4'($urandom));
        b4.mem_rsp_valid = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_fill_valid", 512'(b4.fill_valid), 512'(0));
        chk("t5_ready", 512'(b4.mem_rsp_ready), 512'(1));
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) ya[k] = rnd128();
        addr_a = 26'($urandom); tag_a = 4'($urandom);
        for (int k = 0; k < 4; k++) send_beat(ya[k], addr_a, tag_a);
        b4.mem_rsp_valid = 1'b0;
        tick(3);
        chk("t5_one_line", 512'(q4.size()), 512'(1));
        expect_fill("t5", addr_a, tag_a, mk_line(ya[0], ya[1], ya[2], ya[3]), c);

        // 6: single-beat configuration, random fill_ready and random gaps
        for (int i = 0; i < 40; i++) begin
            int waited = 0;
            w6 = {rnd128(), rnd128(), rnd128(), rnd128()};
            exp6.push_back(w6);
            b1.mem_rsp_valid = 1'b1;
            b1.mem_rsp_data  = w6;
            b1.mem_rsp_addr  = 26'($urandom);
            b1.mem_rsp_tag   = 4'($urandom);
            @(negedge clk);
            while (!b1.mem_rsp_ready && waited < 200) begin
                @(posedge clk); #1;
                b1.fill_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                waited++;
            end
            if (waited >= 200) chk("t6_accept_timeout", 512'(waited < 200), 512'(1));
            @(posedge clk); #1;
            b1.fill_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                b1.mem_rsp_valid = 1'b0;
                tick(1);
            end
        end
        b1.mem_rsp_valid = 1'b0;
        b1.fill_ready = 1'b1;
        tick(4);
        chk("t6_count", 512'(q1.size()), 512'(exp6.size()));
        for (int i = 0; i < 40; i++) begin
            if (q1.size() != 0) chk($sformatf("t6_beat%0d", i), q1.pop_front(), exp6[i]);
        end
        chk("t6_err_tag", 512'(b1.err_tag), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
